// File: rtl/branch_ctrl.sv
// Decode-stage branch/jump sequencer: resolves control transfers,
// schedules the PC redirect behind the delay slot and counts branches.
module branch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [5:0]       id_funct,
  input  logic [15:0]      id_imm,
  input  logic [25:0]      id_index,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      srca,
  input  logic [31:0]      srcb,
  input  logic             opnd_ready,
  input  logic             if_ds_valid,
  input  logic             stall_ex,
  input  logic             flush,
  output logic             stall_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             link_we,
  output logic [4:0]       link_reg,
  output logic [31:0]      link_data,
  output logic             jr_misalign,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPND,
    WAIT_DS
  } state_t;

  state_t      state;
  logic [31:0] pend_pc;
  logic        pend_mis;

  logic op_beq, op_bne, op_blez, op_bgtz;
  logic op_rimm, op_j, op_jal, op_spec;
  logic rt_bltz, rt_bgez, rt_bltzal, rt_bgezal;
  logic is_jr, is_jalr, is_cond, is_jump, is_ct;
  logic need_opnd, is_link, misal;
  logic sa_neg, sa_zero, taken;
  logic [31:0] pc4, br_tgt, j_tgt, target;
  logic [4:0]  lreg;
  logic cand, resolve;

  assign op_beq  = id_op == 6'b000100;
  assign op_bne  = id_op == 6'b000101;
  assign op_blez = id_op == 6'b000110;
  assign op_bgtz = id_op == 6'b000111;
  assign op_rimm = id_op == 6'b000001;
  assign op_j    = id_op == 6'b000010;
  assign op_jal  = id_op == 6'b000011;
  assign op_spec = id_op == 6'b000000;

  assign rt_bltz   = op_rimm && id_rt == 5'b00000;
  assign rt_bgez   = op_rimm && id_rt == 5'b00001;
  assign rt_bltzal = op_rimm && id_rt == 5'b10000;
  assign rt_bgezal = op_rimm && id_rt == 5'b10001;
  assign is_jr     = op_spec && id_funct == 6'b001000;
  assign is_jalr   = op_spec && id_funct == 6'b001001;

  assign is_cond = op_beq | op_bne | op_blez | op_bgtz |
                   rt_bltz | rt_bgez | rt_bltzal | rt_bgezal;
  assign is_jump = op_j | op_jal | is_jr | is_jalr;
  assign is_ct   = is_cond | is_jump;

  assign need_opnd = !(op_j | op_jal);
  assign is_link   = op_jal | rt_bltzal | rt_bgezal | is_jalr;
  assign lreg      = is_jalr ? id_rd : 5'd31;

  assign sa_neg  = srca[31];
  assign sa_zero = srca == 32'd0;

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      op_beq:                taken = srca == srcb;
      op_bne:                taken = srca != srcb;
      op_blez:               taken = sa_neg | sa_zero;
      op_bgtz:               taken = !sa_neg && !sa_zero;
      rt_bltz | rt_bltzal:   taken = sa_neg;
      rt_bgez | rt_bgezal:   taken = !sa_neg;
      is_jump:               taken = 1'b1;
      default:               taken = 1'b0;
    endcase
  end

  assign pc4    = id_pc + 32'd4;
  assign br_tgt = pc4 + {{14{id_imm[15]}}, id_imm, 2'b00};
  assign j_tgt  = {pc4[31:28], id_index, 2'b00};

  always_comb begin
    target = br_tgt;
    unique case (1'b1)
      op_j | op_jal:    target = j_tgt;
      is_jr | is_jalr:  target = srca;
      default:          target = br_tgt;
    endcase
  end

  assign misal = (is_jr | is_jalr) && srca[1:0] != 2'b00;

  // WAIT_DS blocks new transfers: the decode slot holds the delay slot.
  assign cand     = id_valid && is_ct && state != WAIT_DS;
  assign resolve  = cand && (!need_opnd || opnd_ready);
  assign stall_id = cand && need_opnd && !opnd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pend_pc        <= '0;
      pend_mis       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_we        <= 1'b0;
      link_reg       <= '0;
      link_data      <= '0;
      jr_misalign    <= 1'b0;
      br_cnt         <= '0;
      taken_cnt      <= '0;
    end else begin
      redirect_valid <= 1'b0;
      link_we        <= 1'b0;
      jr_misalign    <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        pend_pc  <= '0;
        pend_mis <= 1'b0;
      end else if (!stall_ex) begin
        unique case (state)
          IDLE, WAIT_OPND: begin
            if (resolve) begin
              if (is_link) begin
                link_we   <= 1'b1;
                link_reg  <= lreg;
                link_data <= id_pc + 32'd8;
              end
              if (is_cond) begin
                br_cnt <= br_cnt + 1'b1;
                if (taken)
                  taken_cnt <= taken_cnt + 1'b1;
              end
              if (taken && if_ds_valid) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= target;
                jr_misalign    <= misal;
                state          <= IDLE;
              end else if (taken) begin
                pend_pc  <= target;
                pend_mis <= misal;
                state    <= WAIT_DS;
              end else begin
                state <= IDLE;
              end
            end else if (stall_id) begin
              state <= WAIT_OPND;
            end else begin
              state <= IDLE;
            end
          end
          WAIT_DS: begin
            if (if_ds_valid) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= pend_pc;
              jr_misalign    <= pend_mis;
              state          <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: redirect/link events are queued
// with their due cycle and matched against the DUT on the falling edge.
module tb_branch_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid;
  logic [5:0]   id_op;
  logic [4:0]   id_rt;
  logic [4:0]   id_rd;
  logic [5:0]   id_funct;
  logic [15:0]  id_imm;
  logic [25:0]  id_index;
  logic [31:0]  id_pc;
  logic [31:0]  srca;
  logic [31:0]  srcb;
  logic         opnd_ready;
  logic         if_ds_valid;
  logic         stall_ex;
  logic         flush;
  logic         stall_id;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         link_we;
  logic [4:0]   link_reg;
  logic [31:0]  link_data;
  logic         jr_misalign;
  logic [W-1:0] br_cnt;
  logic [W-1:0] taken_cnt;

  branch_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_op(id_op), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_imm(id_imm), .id_index(id_index),
    .id_pc(id_pc), .srca(srca), .srcb(srcb),
    .opnd_ready(opnd_ready), .if_ds_valid(if_ds_valid),
    .stall_ex(stall_ex), .flush(flush), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_we(link_we), .link_reg(link_reg), .link_data(link_data),
    .jr_misalign(jr_misalign), .br_cnt(br_cnt),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        mis;
  } redir_t;

  typedef struct {
    int          cyc;
    logic [4:0]  r;
    logic [31:0] d;
  } link_t;

  redir_t rq[$];
  link_t  lq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     eb = 0;
  int     et = 0;
  bit     mon_on = 0;
  redir_t mr;
  link_t  ml;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        mr = rq.pop_front();
        chk("redir_v", 32'(redirect_valid), 1);
        chk("redir_pc", redirect_pc, mr.pc);
        chk("misalign", 32'(jr_misalign), 32'(mr.mis));
      end else begin
        chk("redir_spur", 32'(redirect_valid), 0);
      end
      if (lq.size() > 0 && lq[0].cyc == cyc) begin
        ml = lq.pop_front();
        chk("link_we", 32'(link_we), 1);
        chk("link_reg", 32'(link_reg), 32'(ml.r));
        chk("link_data", link_data, ml.d);
      end else begin
        chk("link_spur", 32'(link_we), 0);
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic push_r(input logic [31:0] pc, input logic mis);
    redir_t e;
    e.cyc = cyc + 1;
    e.pc  = pc;
    e.mis = mis;
    rq.push_back(e);
  endtask

  task automatic push_l(input logic [4:0] r, input logic [31:0] d);
    link_t e;
    e.cyc = cyc + 1;
    e.r   = r;
    e.d   = d;
    lq.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy,
                       input logic ds);
    id_valid    = 1'b1;
    id_op       = op;
    id_rt       = rt;
    id_rd       = rd;
    id_funct    = fn;
    id_imm      = imm;
    id_index    = idx;
    id_pc       = pc;
    srca        = a;
    srcb        = b;
    opnd_ready  = rdy;
    if_ds_valid = ds;
  endtask

  task automatic quiet();
    id_valid    = 1'b0;
    flush       = 1'b0;
    stall_ex    = 1'b0;
    if_ds_valid = 1'b0;
    opnd_ready  = 1'b1;
  endtask

  task automatic cnt_chk(input string tag);
    chk({tag, "_br"}, 32'(br_cnt), 32'(eb % 16));
    chk({tag, "_tk"}, 32'(taken_cnt), 32'(et % 16));
  endtask

  function automatic logic [31:0] btgt(input logic [31:0] pc,
                                       input logic [15:0] imm);
    logic [31:0] off;
    off = 32'($signed(imm)) * 4;
    return pc + 32'd4 + off;
  endfunction

  function automatic logic tk_model(input logic [5:0] op,
                                    input logic [4:0] rt,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (op)
      6'd4:    return a == b;
      6'd5:    return a != b;
      6'd6:    return sa <= 0;
      6'd7:    return sa > 0;
      default: return rt[0] ? (sa >= 0) : (sa < 0);
    endcase
  endfunction

  initial begin
    logic [31:0] tgt, a, b, pc;
    logic [15:0] imm;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic        tk;
    bit          wrapped;
    rst = 1'b1;
    quiet();
    issue(6'd4, 0, 0, 0, 16'h1, 0, 32'h40, 0, 0, 1, 1);
    repeat (2) go();
    chk("rst_redir", 32'(redirect_valid), 0);
    chk("rst_link", 32'(link_we), 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_ldata", link_data, 0);
    chk("rst_br", 32'(br_cnt), 0);
    chk("rst_tk", 32'(taken_cnt), 0);
    rst = 1'b0;
    quiet();
    mon_on = 1;
    go();

    // BEQ taken with delay slot already fetched
    issue(6'd4, 0, 0, 0, 16'h0003, 0, 32'h00400000, 5, 5, 1, 1);
    push_r(32'h00400010, 0);
    eb++; et++;
    go(); quiet();
    cnt_chk("beq");

    // BGEZAL not taken still links
    issue(6'd1, 5'b10001, 0, 0, 16'h0010, 0, 32'h100,
          32'hFFFFFFFF, 0, 1, 1);
    push_l(5'd31, 32'h108);
    eb++;
    go(); quiet();
    cnt_chk("bgezal");

    // BNE waits three cycles for operands
    issue(6'd5, 0, 0, 0, 16'hFFFF, 0, 32'h200, 1, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bne_stall", 32'(stall_id), 1);
      go();
    end
    opnd_ready = 1'b1;
    #1 chk("bne_go", 32'(stall_id), 0);
    push_r(32'h200, 0);
    eb++; et++;
    go(); quiet();
    cnt_chk("bne");

    // JAL waits two cycles for the delay slot
    issue(6'd3, 0, 0, 0, 0, 26'h0123456, 32'h3FFFFFFC, 0, 0, 1, 0);
    push_l(5'd31, 32'h40000004);
    go(); quiet();
    #1 chk("wds_stall", 32'(stall_id), 0);
    go();
    if_ds_valid = 1'b1;
    push_r(32'h4048D158, 0);
    go(); quiet();

    // JR misaligned, JALR aligned with rd link
    issue(6'd0, 0, 0, 6'b001000, 0, 0, 32'h300,
          32'h00400002, 0, 1, 1);
    push_r(32'h00400002, 1);
    go(); quiet();
    issue(6'd0, 0, 5'd5, 6'b001001, 0, 0, 32'h500, 32'h2000, 0, 1, 1);
    push_r(32'h2000, 0);
    push_l(5'd5, 32'h508);
    go(); quiet();
    cnt_chk("jumps");

    // flush in WAIT_DS drops the redirect
    issue(6'd2, 0, 0, 0, 0, 26'h40, 32'h1000, 0, 0, 1, 0);
    go(); quiet();
    flush = 1'b1;
    if_ds_valid = 1'b1;
    go();
    flush = 1'b0;
    repeat (2) go();
    quiet();
    issue(6'd4, 0, 0, 0, 16'h0002, 0, 32'h800, 7, 7, 1, 1);
    push_r(32'h80C, 0);
    eb++; et++;
    go(); quiet();
    cnt_chk("after_flush");

    // stall_ex holds a pending target in WAIT_DS
    issue(6'd2, 0, 0, 0, 0, 26'h80, 32'h2000, 0, 0, 1, 0);
    go(); quiet();
    stall_ex = 1'b1;
    if_ds_valid = 1'b1;
    go();
    stall_ex = 1'b0;
    push_r(32'h200, 0);
    go(); quiet();

    // stall_ex delays resolution by one cycle
    issue(6'd4, 0, 0, 0, 16'h0001, 0, 32'h900, 3, 3, 1, 1);
    stall_ex = 1'b1;
    go();
    cnt_chk("sx_hold");
    stall_ex = 1'b0;
    push_r(32'h908, 0);
    eb++; et++;
    go(); quiet();
    cnt_chk("sx_go");

    // flush on the resolve cycle cancels everything
    issue(6'd1, 5'b10001, 0, 0, 16'h4, 0, 32'hA00, 0, 0, 1, 1);
    flush = 1'b1;
    go(); quiet();
    cnt_chk("flush_r");

    // non control-transfer encodings
    issue(6'd1, 5'b00010, 0, 0, 16'h4, 0, 32'hB00, 0, 0, 1, 1);
    go(); quiet();
    issue(6'd0, 0, 0, 6'b001010, 0, 0, 32'hB04, 32'h44, 0, 0, 1);
    #1 chk("nonct_stall", 32'(stall_id), 0);
    go(); quiet();
    cnt_chk("nonct");

    // random conditional branches, crossing the counter wrap
    wrapped = 0;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: begin op = 6'd4; rt = 0; end
        1: begin op = 6'd5; rt = 0; end
        2: begin op = 6'd6; rt = 0; end
        3: begin op = 6'd7; rt = 0; end
        4: begin op = 6'd1; rt = 5'($urandom_range(0, 1)); end
        default: begin
          op = 6'd1;
          rt = 5'h10 | 5'($urandom_range(0, 1));
        end
      endcase
      case ($urandom_range(0, 3))
        0: a = 0;
        1: a = 1;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      b   = $urandom_range(0, 1) ? a : $urandom;
      pc  = $urandom & 32'hFFFFFFFC;
      imm = 16'($urandom);
      issue(op, rt, 0, 0, imm, 0, pc, a, b, 1, 1);
      tk = tk_model(op, rt, a, b);
      tgt = btgt(pc, imm);
      if (tk) push_r(tgt, 0);
      if (op == 6'd1 && rt[4]) push_l(5'd31, pc + 32'd8);
      eb++;
      if (tk) et++;
      go(); quiet();
      cnt_chk("rnd");
      if (eb == 16) begin
        chk("br_wrap", 32'(br_cnt), 0);
        wrapped = 1;
      end
    end
    chk("wrap_seen", 32'(wrapped), 1);

    repeat (3) go();
    chk("rq_empty", rq.size(), 0);
    chk("lq_empty", lq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
